// File: rtl/pulse_sync_rx_multi.sv
// Multi-channel edge-event receiver: per-channel synchronizer, edge detect,
// one-cycle pulse, pending flag with acknowledge, and sticky overflow.
module pulse_sync_rx_multi #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 3,
  parameter int EDGE_MODE   = 0
) (
  input  logic          clkb,
  input  logic          rst_n,
  input  logic [CH-1:0] async_in,
  input  logic [CH-1:0] evt_ack,
  input  logic          ovf_clr,
  output logic [CH-1:0] evt_pulse,
  output logic [CH-1:0] evt_pend,
  output logic [CH-1:0] ovf,
  output logic          any_pend
);

  if (CH < 1 || CH > 32) begin : g_bad_ch
    $error("pulse_sync_rx_multi: CH out of range 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("pulse_sync_rx_multi: SYNC_STAGES out of range 2..4");
  end
  if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
    $error("pulse_sync_rx_multi: EDGE_MODE out of range 0..2");
  end

  logic [CH-1:0] sync_q [SYNC_STAGES];
  logic [CH-1:0] hist;
  logic [CH-1:0] last;
  logic [CH-1:0] detect;
  logic [CH-1:0] pend_n;
  logic [CH-1:0] ovf_n;

  assign last = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      hist <= '0;
    end else begin
      sync_q[0] <= async_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      hist <= last;
    end
  end

  if (EDGE_MODE == 1) begin : g_rise
    assign detect = last & ~hist;
  end else if (EDGE_MODE == 2) begin : g_fall
    assign detect = ~last & hist;
  end else begin : g_any
    assign detect = last ^ hist;
  end

  // A fresh detect beats a same-edge ack; overflow only when unacked.
  always_comb begin
    pend_n = detect | (evt_pend & ~evt_ack);
    ovf_n  = (detect & evt_pend & ~evt_ack)
           | (ovf & {CH{~ovf_clr}});
  end

  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      evt_pulse <= '0;
      evt_pend  <= '0;
      ovf       <= '0;
      any_pend  <= 1'b0;
    end else begin
      evt_pulse <= detect;
      evt_pend  <= pend_n;
      ovf       <= ovf_n;
      any_pend  <= |pend_n;
    end
  end

endmodule

// File: tb/tb_pulse_sync_rx_multi.sv
// Directed bench for pulse_sync_rx_multi: three instances, one per edge
// mode, share stimulus; checks latency, handshake, overflow and reset.
module tb_pulse_sync_rx_multi;

  logic       clkb = 1'b0;
  logic       rst_n;
  logic [3:0] async_in;
  logic [3:0] evt_ack;
  logic       ovf_clr;

  logic [3:0] p0, e0, o0;
  logic       a0;
  logic [3:0] p1, e1, o1;
  logic       a1;
  logic [3:0] p2, e2, o2;
  logic       a2;

  int total = 0;
  int bad   = 0;
  logic [3:0] seen;

  always #5 clkb = ~clkb;

  pulse_sync_rx_multi #(.CH(4), .SYNC_STAGES(3), .EDGE_MODE(0)) d0 (
    .clkb(clkb), .rst_n(rst_n), .async_in(async_in), .evt_ack(evt_ack),
    .ovf_clr(ovf_clr), .evt_pulse(p0), .evt_pend(e0), .ovf(o0),
    .any_pend(a0)
  );
  pulse_sync_rx_multi #(.CH(4), .SYNC_STAGES(3), .EDGE_MODE(1)) d1 (
    .clkb(clkb), .rst_n(rst_n), .async_in(async_in), .evt_ack(evt_ack),
    .ovf_clr(ovf_clr), .evt_pulse(p1), .evt_pend(e1), .ovf(o1),
    .any_pend(a1)
  );
  pulse_sync_rx_multi #(.CH(4), .SYNC_STAGES(3), .EDGE_MODE(2)) d2 (
    .clkb(clkb), .rst_n(rst_n), .async_in(async_in), .evt_ack(evt_ack),
    .ovf_clr(ovf_clr), .evt_pulse(p2), .evt_pend(e2), .ovf(o2),
    .any_pend(a2)
  );

  task automatic tick();
    @(posedge clkb);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    async_in = 4'h0;
    evt_ack  = 4'h0;
    ovf_clr  = 1'b0;
    #12;
    chk("rst_pulse", {28'd0, p0}, 32'h0);
    chk("rst_pend",  {28'd0, e0}, 32'h0);
    chk("rst_ovf",   {28'd0, o0}, 32'h0);
    chk("rst_any",   {31'd0, a0}, 32'h0);
    tick();
    rst_n = 1'b1;
    ticks(4);
    chk("idle_pulse", {28'd0, p0}, 32'h0);

    // latency: 0->1 on ch0
    async_in[0] = 1'b1;
    ticks(3);
    chk("lat_early", {31'd0, p0[0]}, 32'h0);
    tick();
    chk("lat_pulse_m0", {31'd0, p0[0]}, 32'h1);
    chk("lat_pend_m0",  {31'd0, e0[0]}, 32'h1);
    chk("lat_any_m0",   {31'd0, a0},    32'h1);
    chk("rise_m1",      {31'd0, p1[0]}, 32'h1);
    chk("rise_m2",      {31'd0, p2[0]}, 32'h0);
    tick();
    chk("lat_one_cycle", {31'd0, p0[0]}, 32'h0);
    chk("pend_hold",     {31'd0, e0[0]}, 32'h1);

    // fall on ch0
    async_in[0] = 1'b0;
    ticks(4);
    chk("fall_m0", {31'd0, p0[0]}, 32'h1);
    chk("fall_m1", {31'd0, p1[0]}, 32'h0);
    chk("fall_m2", {31'd0, p2[0]}, 32'h1);
    chk("fall_ovf_m0", {31'd0, o0[0]}, 32'h1);
    chk("fall_ovf_m2", {31'd0, o2[0]}, 32'h0);
    evt_ack = 4'hF;
    ovf_clr = 1'b1;
    tick();
    evt_ack = 4'h0;
    ovf_clr = 1'b0;
    chk("clr_pend", {28'd0, e0}, 32'h0);
    chk("clr_ovf",  {28'd0, o0}, 32'h0);
    chk("clr_any",  {31'd0, a0}, 32'h0);

    // handshake on ch1
    async_in[1] = 1'b1;
    ticks(4);
    chk("hs_pend", {28'd0, e0}, 32'h2);
    ticks(2);
    evt_ack[1] = 1'b1;
    tick();
    evt_ack[1] = 1'b0;
    chk("hs_ack_pend", {31'd0, e0[1]}, 32'h0);
    chk("hs_ack_ovf",  {31'd0, o0[1]}, 32'h0);
    evt_ack[1] = 1'b1;
    tick();
    evt_ack[1] = 1'b0;
    chk("stray_pend",  {28'd0, e0}, 32'h0);
    chk("stray_ovf",   {28'd0, o0}, 32'h0);
    chk("stray_pulse", {28'd0, p0}, 32'h0);

    // overflow and clear on ch2
    async_in[2] = 1'b1;
    ticks(4);
    chk("ov_first_pend", {31'd0, e0[2]}, 32'h1);
    chk("ov_first_ovf",  {31'd0, o0[2]}, 32'h0);
    async_in[2] = 1'b0;
    ticks(4);
    chk("ov_second_pulse", {31'd0, p0[2]}, 32'h1);
    chk("ov_set",          {28'd0, o0},    32'h4);
    chk("ov_pend",         {31'd0, e0[2]}, 32'h1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovclr_alone", {28'd0, o0}, 32'h0);
    async_in[2] = 1'b1;
    ticks(3);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovclr_vs_evt_pulse", {31'd0, p0[2]}, 32'h1);
    chk("ovclr_vs_evt_ovf",   {31'd0, o0[2]}, 32'h1);

    // simultaneous detect and ack on ch3
    async_in[3] = 1'b1;
    ticks(4);
    chk("sim_first_pend", {31'd0, e0[3]}, 32'h1);
    async_in[3] = 1'b0;
    ticks(3);
    evt_ack[3] = 1'b1;
    tick();
    evt_ack[3] = 1'b0;
    chk("sim_pulse", {31'd0, p0[3]}, 32'h1);
    chk("sim_pend",  {31'd0, e0[3]}, 32'h1);
    chk("sim_ovf",   {31'd0, o0[3]}, 32'h0);

    // reset with events in flight
    async_in = ~async_in;
    ticks(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pulse", {28'd0, p0}, 32'h0);
    chk("mid_rst_pend",  {28'd0, e0}, 32'h0);
    chk("mid_rst_ovf",   {28'd0, o0}, 32'h0);
    chk("mid_rst_any",   {31'd0, a0}, 32'h0);
    chk("mid_rst_ovf_m1", {28'd0, o1}, 32'h0);
    async_in = 4'h0;
    tick();
    rst_n = 1'b1;
    seen = 4'h0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | p0 | p1 | p2;
    end
    chk("post_rst_quiet", {28'd0, seen}, 32'h0);
    chk("post_rst_pend",  {28'd0, e0},   32'h0);

    // high input at reset release yields one event
    rst_n = 1'b0;
    async_in = 4'h1;
    tick();
    rst_n = 1'b1;
    ticks(3);
    chk("rel_early", {31'd0, p0[0]}, 32'h0);
    tick();
    chk("rel_pulse_m0", {28'd0, p0}, 32'h1);
    chk("rel_pulse_m1", {28'd0, p1}, 32'h1);
    chk("rel_pulse_m2", {28'd0, p2}, 32'h0);
    tick();
    chk("rel_single", {28'd0, p0}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_sync_rx_multi.md
PULSE_SYNC_RX_MULTI -- requirements
Module: pulse_sync_rx_multi

Interface
REQ-001 SHALL provide parameter CH, default 4, number of independent event channels; legal range 1..32.
REQ-002 SHALL provide parameter SYNC_STAGES, default 3, synchronizer flop depth per channel; legal range 2..4.
REQ-003 SHALL provide parameter EDGE_MODE, default 0, event definition for all channels: 0 any edge (toggle), 1 rising edge, 2 falling edge.
REQ-004 SHALL reject at elaboration any out-of-range CH, SYNC_STAGES or EDGE_MODE.
REQ-005 clkb  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 async_in  input  CH  per-channel asynchronous level/toggle signal from a foreign domain.
REQ-008 evt_ack  input  CH  per-channel acknowledge of a pending event.
REQ-009 ovf_clr  input  1  clears all sticky overflow flags.
REQ-010 evt_pulse  output  CH  registered one-cycle pulse per detected event.
REQ-011 evt_pend  output  CH  registered per-channel pending flag, held until acknowledged.
REQ-012 ovf  output  CH  registered sticky per-channel overflow flag.
REQ-013 any_pend  output  1  registered OR of the next-state evt_pend bits, so it is coincident with evt_pend.

Function
REQ-014 Each channel SHALL pass async_in[i] through a SYNC_STAGES-deep flop chain, followed by one history flop (hist) fed from the last chain stage.
REQ-015 Detect[i] SHALL be last^hist (mode 0), last&~hist (mode 1), or ~last&hist (mode 2).
REQ-016 evt_pulse[i] SHALL be the registered detect[i]; it is high for exactly one clkb cycle per event.
REQ-017 Latency: an async_in change sampled at edge k SHALL give evt_pulse high from edge k+SYNC_STAGES to edge k+SYNC_STAGES+1, i.e. SYNC_STAGES+1 edges counting edge k as edge 1.
REQ-018 evt_pend[i] SHALL set on the same edge as evt_pulse[i] rises.
REQ-019 evt_pend[i] SHALL clear on an edge where evt_ack[i]=1 and evt_pend[i]=1.
REQ-020 evt_ack[i] with evt_pend[i]=0 SHALL be ignored and SHALL have no side effect.
REQ-021 Detect and ack on the same edge SHALL leave evt_pend[i]=1 (new event wins), with no overflow.
REQ-022 Detect while evt_pend[i]=1 and evt_ack[i]=0 SHALL set ovf[i]; evt_pend stays 1 and evt_pulse still fires.
REQ-023 ovf_clr=1 SHALL clear all ovf bits on that edge; an overflow condition on the same edge SHALL win, leaving that bit set.
REQ-024 Channels SHALL be fully independent; no cross-channel priority or interaction except any_pend.
REQ-025 Input toggles spaced closer than 2 clkb cycles are outside the contract; no event ordering is guaranteed for them.

Reset
REQ-026 rst_n low SHALL asynchronously force all sync, hist, evt_pulse, evt_pend, ovf and any_pend flops to 0.
REQ-027 On release the block SHALL resume on the first clkb edge with rst_n high.
REQ-028 async_in high at reset release SHALL produce one event in modes 0 and 1, SYNC_STAGES+1 edges later, because hist resets to 0.
REQ-029 Reset asserted mid-event SHALL discard pending events and overflow with no residual pulse after release.

Verification
REQ-030 Latency: CH=4, SYNC_STAGES=3, mode 0; toggle async_in[0] 0->1 -> evt_pulse[0] high exactly one cycle, 4 edges after first sampling; evt_pend[0]=1 and any_pend=1 on the same edge.
REQ-031 Modes: mode 1 with rise then fall -> one pulse; mode 2 with the same stimulus -> one pulse on the fall; mode 0 -> two pulses.
REQ-032 Handshake: event, then evt_ack[1] 3 cycles later -> evt_pend[1] clears on that edge and ovf[1] stays 0; a stray ack with pend=0 changes nothing.
REQ-033 Overflow and clear: two events on ch2 with no ack -> ovf[2]=1, evt_pend[2]=1; ovf_clr alone -> ovf[2]=0; ovf_clr coincident with a third unacked event -> ovf[2]=1.
REQ-034 Simultaneous detect and ack: ack ch3 on the edge where a new event is detected -> evt_pend[3] stays 1, ovf[3]=0.
REQ-035 Reset: assert rst_n with events in flight on all channels -> all outputs 0 immediately with no clock; release with async_in=0 -> no pulses.
